// File: rtl/ofdm_pkg.sv
// Purpose: shared types and default sizing for the OFDM transmit chain (IFFT + CP insertion).
// Latency: n/a (declarations only).
// Backpressure: n/a.
package ofdm_pkg;

  // Defaults shared with the IFFT stages so the whole chain agrees on sizing.
  localparam int OFDM_DATA_WIDTH = 16;
  localparam int OFDM_N          = 64;
  localparam int OFDM_CP_LEN     = 16;

  // Read-side state. PREFIX/BODY name the region of the *next* index to load.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    PREFIX = 2'd1,
    BODY   = 2'd2
  } rd_state_t;

endpackage

// File: rtl/cp_sym_buffer.sv
// Purpose: two-bank symbol store, one synchronous write port, one asynchronous read port.
// Latency: write visible on the read port the cycle after the write edge; read is combinational.
// Backpressure: none; the owner guarantees a bank is never written while it is being read.
// Ports: clk; wr_en_i/wr_bank_i/wr_idx_i/wr_re_i/wr_im_i write port;
//        rd_bank_i/rd_idx_i select, rd_re_o/rd_im_o read data.
module cp_sym_buffer #(
  parameter  int DATA_WIDTH = 16,
  parameter  int N          = 64,
  localparam int AW         = $clog2(N)
) (
  input  logic                  clk,
  input  logic                  wr_en_i,
  input  logic                  wr_bank_i,
  input  logic [AW-1:0]         wr_idx_i,
  input  logic [DATA_WIDTH-1:0] wr_re_i,
  input  logic [DATA_WIDTH-1:0] wr_im_i,
  input  logic                  rd_bank_i,
  input  logic [AW-1:0]         rd_idx_i,
  output logic [DATA_WIDTH-1:0] rd_re_o,
  output logic [DATA_WIDTH-1:0] rd_im_o
);

  // Contents are deliberately not reset: the full flags decide what is meaningful.
  logic [2*DATA_WIDTH-1:0] mem_q [2][N];

  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      mem_q[wr_bank_i][wr_idx_i] <= {wr_re_i, wr_im_i};
    end
  end

  assign {rd_re_o, rd_im_o} = mem_q[rd_bank_i][rd_idx_i];

endmodule

// File: rtl/ofdm_cp_inserter.sv
// Purpose: cyclic-prefix insertion; buffers N-sample symbols ping-pong, emits last CP_LEN then all N.
// Latency: last input accepted at edge k -> first prefix sample valid after edge k+1 (reader idle).
// Backpressure: in_ready low while the write bank is full; output register holds while out_ready low.
// Ports: clk, reset (sync, active-low); in_valid/in_ready/in_re/in_im input stream;
//        out_valid/out_ready/out_re/out_im/out_last output stream (out_last on final sample of symbol).
module ofdm_cp_inserter
  import ofdm_pkg::*;
#(
  parameter int DATA_WIDTH = OFDM_DATA_WIDTH,
  parameter int N          = OFDM_N,
  parameter int CP_LEN     = OFDM_CP_LEN
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_re,
  input  logic [DATA_WIDTH-1:0] in_im,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_re,
  output logic [DATA_WIDTH-1:0] out_im,
  output logic                  out_last
);

  localparam int AW = $clog2(N);
  localparam logic [AW-1:0] IDX_LAST = AW'(N - 1);
  localparam logic [AW-1:0] IDX_ONE  = AW'(1);
  // First index emitted per symbol; N-CP_LEN truncates to 0 when CP_LEN == 0.
  localparam logic [AW-1:0] START_IDX = AW'(N - CP_LEN);

  // Write side
  logic          wr_bank_q, wr_bank_d;
  logic [AW-1:0] wr_idx_q, wr_idx_d;
  logic [1:0]    full_q, full_d;
  logic          wr_en;

  // Read side
  rd_state_t     state_q, state_d, region;
  logic          rd_bank_q, rd_bank_d;
  logic [AW-1:0] rd_idx_q, rd_idx_d;
  logic [AW-1:0] ld_idx;
  logic          advance, load, ld_last, clr_full;

  // Output register
  logic                  out_valid_q, out_valid_d;
  logic                  out_last_q, out_last_d;
  logic [DATA_WIDTH-1:0] out_re_q, out_re_d, out_im_q, out_im_d;
  logic [DATA_WIDTH-1:0] rd_re, rd_im;

  assign in_ready = reset && !full_q[wr_bank_q];
  assign wr_en    = in_valid && in_ready;
  assign advance  = !out_valid_q || out_ready;

  cp_sym_buffer #(
    .DATA_WIDTH (DATA_WIDTH),
    .N          (N)
  ) u_buf (
    .clk       (clk),
    .wr_en_i   (wr_en),
    .wr_bank_i (wr_bank_q),
    .wr_idx_i  (wr_idx_q),
    .wr_re_i   (in_re),
    .wr_im_i   (in_im),
    .rd_bank_i (rd_bank_q),
    .rd_idx_i  (ld_idx),
    .rd_re_o   (rd_re),
    .rd_im_o   (rd_im)
  );

  // Read FSM: decides whether this cycle loads the output register and what comes next.
  always_comb begin
    state_d   = state_q;
    rd_bank_d = rd_bank_q;
    rd_idx_d  = rd_idx_q;
    region    = state_q;
    ld_idx    = rd_idx_q;
    load      = 1'b0;
    ld_last   = 1'b0;
    clr_full  = 1'b0;

    if (advance) begin
      unique case (state_q)
        IDLE: begin
          if (full_q[rd_bank_q]) begin
            load   = 1'b1;
            ld_idx = START_IDX;
            if (CP_LEN > 0) region = PREFIX;
            else            region = BODY;
          end
        end
        default: load = 1'b1;
      endcase
    end

    if (load) begin
      if (region == PREFIX) begin
        if (ld_idx == IDX_LAST) begin
          state_d  = BODY;
          rd_idx_d = '0;
        end else begin
          state_d  = PREFIX;
          rd_idx_d = ld_idx + IDX_ONE;
        end
      end else if (ld_idx == IDX_LAST) begin
        // Final sample of the symbol: release the bank and chain into the next one if ready.
        ld_last   = 1'b1;
        clr_full  = 1'b1;
        rd_bank_d = ~rd_bank_q;
        rd_idx_d  = START_IDX;
        if (!full_q[~rd_bank_q]) state_d = IDLE;
        else if (CP_LEN > 0)     state_d = PREFIX;
        else                     state_d = BODY;
      end else begin
        state_d  = BODY;
        rd_idx_d = ld_idx + IDX_ONE;
      end
    end
  end

  // Write pointer and full flags. The two banks touched here are always distinct.
  always_comb begin
    wr_bank_d = wr_bank_q;
    wr_idx_d  = wr_idx_q;
    full_d    = full_q;
    if (wr_en) begin
      if (wr_idx_q == IDX_LAST) begin
        full_d[wr_bank_q] = 1'b1;
        wr_bank_d         = ~wr_bank_q;
        wr_idx_d          = '0;
      end else begin
        wr_idx_d = wr_idx_q + IDX_ONE;
      end
    end
    if (clr_full) begin
      full_d[rd_bank_q] = 1'b0;
    end
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    out_re_d    = out_re_q;
    out_im_d    = out_im_q;
    if (load) begin
      out_valid_d = 1'b1;
      out_last_d  = ld_last;
      out_re_d    = rd_re;
      out_im_d    = rd_im;
    end else if (advance) begin
      out_valid_d = 1'b0;
      out_last_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_bank_q   <= 1'b0;
      wr_idx_q    <= '0;
      full_q      <= '0;
      state_q     <= IDLE;
      rd_bank_q   <= 1'b0;
      rd_idx_q    <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_re_q    <= '0;
      out_im_q    <= '0;
    end else begin
      wr_bank_q   <= wr_bank_d;
      wr_idx_q    <= wr_idx_d;
      full_q      <= full_d;
      state_q     <= state_d;
      rd_bank_q   <= rd_bank_d;
      rd_idx_q    <= rd_idx_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      out_re_q    <= out_re_d;
      out_im_q    <= out_im_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign out_re    = out_re_q;
  assign out_im    = out_im_q;

endmodule

// File: tb/tb_ofdm_cp_inserter.sv
// Purpose: directed self-checking bench for ofdm_cp_inserter (N=8 with CP_LEN=2 and CP_LEN=0 builds).
// Latency: n/a.
// Backpressure: n/a.
module tb_ofdm_cp_inserter;

  localparam int DW = 16;

  logic          clk;
  logic          reset;
  logic          in_valid, in_ready, out_valid, out_ready, out_last;
  logic [DW-1:0] in_re, in_im, out_re, out_im;
  logic          z_in_valid, z_in_ready, z_out_valid, z_out_ready, z_out_last;
  logic [DW-1:0] z_in_re, z_in_im, z_out_re, z_out_im;

  ofdm_cp_inserter #(.DATA_WIDTH(DW), .N(8), .CP_LEN(2)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_re(in_re), .in_im(in_im),
    .out_valid(out_valid), .out_ready(out_ready), .out_re(out_re), .out_im(out_im),
    .out_last(out_last)
  );

  ofdm_cp_inserter #(.DATA_WIDTH(DW), .N(8), .CP_LEN(0)) dut0 (
    .clk(clk), .reset(reset),
    .in_valid(z_in_valid), .in_ready(z_in_ready), .in_re(z_in_re), .in_im(z_in_im),
    .out_valid(z_out_valid), .out_ready(z_out_ready), .out_re(z_out_re), .out_im(z_out_im),
    .out_last(z_out_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int last_in_cyc = -1;

  logic [DW-1:0] src_re[$], src_im[$];
  logic [DW-1:0] got_re[$], got_im[$];
  logic          got_last[$];
  int            got_cyc[$];
  logic          ir_hist[$];

  // Queue one 8-sample symbol with re=k, im=-k.
  task automatic push_sym(input int base);
    for (int k = base; k < base + 8; k++) begin
      src_re.push_back(16'(k));
      src_im.push_back(16'(-k));
    end
  endtask

  task automatic clear_q();
    src_re.delete(); src_im.delete();
    got_re.delete(); got_im.delete(); got_last.delete(); got_cyc.delete();
    ir_hist.delete();
    cyc = 0;
    last_in_cyc = -1;
  endtask

  // One cycle on the main DUT: drive from src queue, record handshakes, advance past the edge.
  task automatic tick();
    in_valid = (src_re.size() != 0);
    in_re    = in_valid ? src_re[0] : '0;
    in_im    = in_valid ? src_im[0] : '0;
    #1;
    ir_hist.push_back(in_ready);
    if (in_valid && in_ready) begin
      src_re.delete(0);
      src_im.delete(0);
      last_in_cyc = cyc;
    end
    if (out_valid && out_ready) begin
      got_re.push_back(out_re);
      got_im.push_back(out_im);
      got_last.push_back(out_last);
      got_cyc.push_back(cyc);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    cyc++;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    in_valid = 1'b0; in_re = '0; in_im = '0; out_ready = 1'b1;
    z_in_valid = 1'b0; z_in_re = '0; z_in_im = '0; z_out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    clear_q();
  endtask

  task automatic test_reset();
    reset = 1'b0;
    in_valid = 1'b0; in_re = '0; in_im = '0; out_ready = 1'b1;
    z_in_valid = 1'b0; z_in_re = '0; z_in_im = '0; z_out_ready = 1'b1;
    @(posedge clk); #1;
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL reset_in_ready_low got=%b want=0", in_ready); end
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
    checks++; if (out_re !== 16'h0 || out_im !== 16'h0) begin failures++; $display("FAIL reset_out_data got=%h/%h want=0000/0000", out_re, out_im); end
    checks++; if (out_last !== 1'b0) begin failures++; $display("FAIL reset_out_last got=%b want=0", out_last); end
    checks++; if (z_out_valid !== 1'b0) begin failures++; $display("FAIL reset_cp0_out_valid got=%b want=0", z_out_valid); end
    reset = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_release_in_ready got=%b want=1", in_ready); end
    clear_q();
  endtask

  task automatic test_single();
    int e;
    do_reset();
    push_sym(0);
    for (int c = 0; c < 100 && got_re.size() < 10; c++) tick();
    checks++; if (got_re.size() != 10) begin failures++; $display("FAIL single_count got=%0d want=10", got_re.size()); end
    for (int i = 0; i < got_re.size() && i < 10; i++) begin
      e = (i < 2) ? 6 + i : i - 2;
      checks++;
      if (got_re[i] !== 16'(e) || got_im[i] !== 16'(-e) || got_last[i] !== (i == 9)) begin
        failures++;
        $display("FAIL single_out[%0d] got=%h/%h/%b want=%h/%h/%b", i, got_re[i], got_im[i], got_last[i], 16'(e), 16'(-e), (i == 9));
      end
    end
    // Last input accepted in tick c; reader loads at the end of tick c+1; visible in tick c+2.
    if (got_cyc.size() == 10) begin
      checks++; if (got_cyc[0] != last_in_cyc + 2) begin failures++; $display("FAIL single_latency got=%0d want=%0d", got_cyc[0], last_in_cyc + 2); end
      checks++; if (got_cyc[9] - got_cyc[0] != 9) begin failures++; $display("FAIL single_contiguous got=%0d want=9", got_cyc[9] - got_cyc[0]); end
    end
    tick(); tick();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL single_drained got=%b want=0", out_valid); end
  endtask

  task automatic test_back_to_back();
    int e, s, j;
    do_reset();
    push_sym(0); push_sym(8); push_sym(16);
    for (int c = 0; c < 200 && got_re.size() < 30; c++) tick();
    checks++; if (got_re.size() != 30) begin failures++; $display("FAIL b2b_count got=%0d want=30", got_re.size()); end
    for (int i = 0; i < got_re.size() && i < 30; i++) begin
      s = i / 10; j = i % 10;
      e = (j < 2) ? 8 * s + 6 + j : 8 * s + j - 2;
      checks++;
      if (got_re[i] !== 16'(e) || got_im[i] !== 16'(-e) || got_last[i] !== (j == 9) || got_cyc[i] != got_cyc[0] + i) begin
        failures++;
        $display("FAIL b2b_out[%0d] got=%h/%h/%b@%0d want=%h/%h/%b@%0d", i, got_re[i], got_im[i], got_last[i], got_cyc[i], 16'(e), 16'(-e), (j == 9), got_cyc[0] + i);
      end
    end
    // Both banks full after tick 15; bank 0 frees at the end of tick 17.
    if (ir_hist.size() > 18) begin
      checks++;
      if (ir_hist[15] !== 1'b1 || ir_hist[16] !== 1'b0 || ir_hist[17] !== 1'b0 || ir_hist[18] !== 1'b1) begin
        failures++;
        $display("FAIL b2b_in_ready got=%b%b%b%b want=1001", ir_hist[15], ir_hist[16], ir_hist[17], ir_hist[18]);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [15:0] lfsr;
    logic        stalled, snap_v, snap_l;
    logic [DW-1:0] snap_re, snap_im;
    int e, s, j;
    lfsr = 16'hACE1;
    do_reset();
    push_sym(0); push_sym(8);
    for (int c = 0; c < 400 && got_re.size() < 20; c++) begin
      lfsr = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
      out_ready = lfsr[0];
      stalled = out_valid && !out_ready;
      snap_v = out_valid; snap_l = out_last; snap_re = out_re; snap_im = out_im;
      tick();
      if (stalled) begin
        checks++;
        if (out_valid !== snap_v || out_last !== snap_l || out_re !== snap_re || out_im !== snap_im) begin
          failures++;
          $display("FAIL bp_stall_hold got=%b/%h/%h/%b want=%b/%h/%h/%b", out_valid, out_re, out_im, out_last, snap_v, snap_re, snap_im, snap_l);
        end
      end
    end
    out_ready = 1'b1;
    checks++; if (got_re.size() != 20) begin failures++; $display("FAIL bp_count got=%0d want=20", got_re.size()); end
    for (int i = 0; i < got_re.size() && i < 20; i++) begin
      s = i / 10; j = i % 10;
      e = (j < 2) ? 8 * s + 6 + j : 8 * s + j - 2;
      checks++;
      if (got_re[i] !== 16'(e) || got_im[i] !== 16'(-e) || got_last[i] !== (j == 9)) begin
        failures++;
        $display("FAIL bp_out[%0d] got=%h/%h/%b want=%h/%h/%b", i, got_re[i], got_im[i], got_last[i], 16'(e), 16'(-e), (j == 9));
      end
    end
  endtask

  task automatic test_cp0();
    logic [DW-1:0] zr[8], zm[8];
    logic          zl[8];
    int zi, zn;
    do_reset();
    zi = 0; zn = 0;
    for (int c = 0; c < 60 && zn < 8; c++) begin
      z_in_valid = (zi < 8);
      z_in_re = 16'(zi);
      z_in_im = 16'(-zi);
      #1;
      if (z_in_valid && z_in_ready) zi++;
      if (z_out_valid && z_out_ready) begin
        zr[zn] = z_out_re; zm[zn] = z_out_im; zl[zn] = z_out_last; zn++;
      end
      @(posedge clk); #1;
    end
    z_in_valid = 1'b0;
    checks++; if (zn != 8) begin failures++; $display("FAIL cp0_count got=%0d want=8", zn); end
    for (int i = 0; i < zn; i++) begin
      checks++;
      if (zr[i] !== 16'(i) || zm[i] !== 16'(-i) || zl[i] !== (i == 7)) begin
        failures++;
        $display("FAIL cp0_out[%0d] got=%h/%h/%b want=%h/%h/%b", i, zr[i], zm[i], zl[i], 16'(i), 16'(-i), (i == 7));
      end
    end
  endtask

  task automatic mid_reset(input string tag);
    reset = 1'b0;
    in_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL %s_out_valid got=%b want=0", tag, out_valid); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL %s_in_ready got=%b want=1", tag, in_ready); end
    clear_q();
  endtask

  task automatic test_reset_mid();
    int e;
    do_reset();
    push_sym(0);
    for (int c = 0; c < 60 && got_re.size() < 4; c++) tick();
    checks++; if (got_re.size() != 4) begin failures++; $display("FAIL midrd_pre_count got=%0d want=4", got_re.size()); end
    mid_reset("midrd");
    // Hold the output so symbol 0 stays resident while symbol 1 is partly written.
    out_ready = 1'b0;
    push_sym(0);
    for (int k = 8; k < 11; k++) begin src_re.push_back(16'(k)); src_im.push_back(16'(-k)); end
    for (int c = 0; c < 60 && src_re.size() != 0; c++) tick();
    checks++; if (src_re.size() != 0) begin failures++; $display("FAIL midwr_pre_left got=%0d want=0", src_re.size()); end
    mid_reset("midwr");
    out_ready = 1'b1;
    push_sym(100);
    for (int c = 0; c < 100 && got_re.size() < 10; c++) tick();
    checks++; if (got_re.size() != 10) begin failures++; $display("FAIL fresh_count got=%0d want=10", got_re.size()); end
    for (int i = 0; i < got_re.size() && i < 10; i++) begin
      e = (i < 2) ? 106 + i : 100 + i - 2;
      checks++;
      if (got_re[i] !== 16'(e) || got_im[i] !== 16'(-e) || got_last[i] !== (i == 9)) begin
        failures++;
        $display("FAIL fresh_out[%0d] got=%h/%h/%b want=%h/%h/%b", i, got_re[i], got_im[i], got_last[i], 16'(e), 16'(-e), (i == 9));
      end
    end
  endtask

  task automatic test_fullscale();
    do_reset();
    for (int k = 0; k < 8; k++) begin src_re.push_back(16'h8000); src_im.push_back(16'h7FFF); end
    for (int c = 0; c < 100 && got_re.size() < 10; c++) tick();
    checks++; if (got_re.size() != 10) begin failures++; $display("FAIL fs_count got=%0d want=10", got_re.size()); end
    for (int i = 0; i < got_re.size() && i < 10; i++) begin
      checks++;
      if (got_re[i] !== 16'h8000 || got_im[i] !== 16'h7FFF || got_last[i] !== (i == 9)) begin
        failures++;
        $display("FAIL fs_out[%0d] got=%h/%h/%b want=8000/7fff/%b", i, got_re[i], got_im[i], got_last[i], (i == 9));
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_cp0();
    test_reset_mid();
    test_fullscale();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
